// File: rtl/pcie_block_lock_ctrl.sv
// 128b/130b block-alignment controller: hunts for the block boundary via gearbox slips, tracks lock.
// Optional saturating illegal-header counter on err_cnt when PCIE_BLOCK_LOCK_ERR_CNT_EN is defined.
module pcie_block_lock_ctrl #(
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned WIN_LEN    = 64,
    parameter int unsigned BAD_THRESH = 16,
    parameter int unsigned SLIP_WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        hdr_valid,
    input  logic        hdr_err,
    output logic        slip,
    output logic        block_lock,
    output logic        lock_lost,
    output logic        blk_valid
`ifdef PCIE_BLOCK_LOCK_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [2:0] ST_HUNT   = 3'd0;
    localparam logic [2:0] ST_TEST   = 3'd1;
    localparam logic [2:0] ST_SLIP   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;

    localparam logic [7:0] LOCK_CNT_C   = 8'(LOCK_CNT);
    localparam logic [7:0] WIN_LEN_C    = 8'(WIN_LEN);
    localparam logic [7:0] BAD_THRESH_C = 8'(BAD_THRESH);
    localparam logic [3:0] SLIP_WAIT_C  = 4'(SLIP_WAIT);

    logic [2:0] state_q, state_d;
    logic [7:0] good_cnt_q, good_cnt_d;
    logic [7:0] win_cnt_q, win_cnt_d;
    logic [7:0] bad_cnt_q, bad_cnt_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       slip_q, slip_d;
    logic       lock_q, lock_d;
    logic       lost_q, lost_d;

    logic good_hdr, bad_hdr;
    logic [7:0] good_inc, win_inc, bad_inc;

    assign good_hdr = hdr_valid & ~hdr_err;
    assign bad_hdr  = hdr_valid & hdr_err;
    assign good_inc = good_cnt_q + 8'd1;
    assign win_inc  = win_cnt_q + 8'd1;
    assign bad_inc  = bad_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        win_cnt_d  = win_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        wait_cnt_d = wait_cnt_q;
        lock_d     = lock_q;
        lost_d     = 1'b0;

        // Disable overrides every state transition, including a coincident lock loss.
        if (!enable) begin
            state_d    = ST_HUNT;
            good_cnt_d = '0;
            win_cnt_d  = '0;
            bad_cnt_d  = '0;
            wait_cnt_d = '0;
            lock_d     = 1'b0;
            lost_d     = (state_q == ST_LOCKED);
        end else begin
            case (state_q)
                ST_HUNT: begin
                    good_cnt_d = '0;
                    win_cnt_d  = '0;
                    bad_cnt_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = ST_TEST;
                end
                ST_TEST: begin
                    if (good_hdr) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_CNT_C) begin
                            state_d    = ST_LOCKED;
                            lock_d     = 1'b1;
                            good_cnt_d = '0;
                            win_cnt_d  = '0;
                            bad_cnt_d  = '0;
                        end
                    end else if (bad_hdr) begin
                        state_d = ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    wait_cnt_d = SLIP_WAIT_C;
                    good_cnt_d = '0;
                    win_cnt_d  = '0;
                    bad_cnt_d  = '0;
                    state_d    = (SLIP_WAIT_C == 4'd0) ? ST_TEST : ST_WAIT;
                end
                ST_WAIT: begin
                    if (hdr_valid) begin
                        wait_cnt_d = wait_cnt_q - 4'd1;
                        if (wait_cnt_q <= 4'd1) begin
                            state_d = ST_TEST;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (hdr_valid) begin
                        win_cnt_d = win_inc;
                        if (bad_hdr) begin
                            bad_cnt_d = bad_inc;
                        end
                        // Threshold check precedes the window rollover so loss wins on block WIN_LEN.
                        if (bad_hdr && (bad_inc == BAD_THRESH_C)) begin
                            state_d   = ST_SLIP;
                            lock_d    = 1'b0;
                            lost_d    = 1'b1;
                            win_cnt_d = '0;
                            bad_cnt_d = '0;
                        end else if (win_inc == WIN_LEN_C) begin
                            win_cnt_d = '0;
                            bad_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    lock_d  = 1'b0;
                end
            endcase
        end

        slip_d = (state_d == ST_SLIP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            good_cnt_q <= '0;
            win_cnt_q  <= '0;
            bad_cnt_q  <= '0;
            wait_cnt_q <= '0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            win_cnt_q  <= win_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            slip_q     <= slip_d;
            lock_q     <= lock_d;
            lost_q     <= lost_d;
        end
    end

    assign slip       = slip_q;
    assign block_lock = lock_q;
    assign lock_lost  = lost_q;
    assign blk_valid  = hdr_valid & lock_q & ~hdr_err;

`ifdef PCIE_BLOCK_LOCK_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bad_hdr && (state_q != ST_WAIT) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
